// File: rtl/digilock_pkg.sv
// Shared definitions for the digital code lock: FSM state encoding and
// default sizing of code length, retry limit and lockout time.
package digilock_pkg;

  typedef enum logic [1:0] {
    ESPERA   = 2'd0,
    SOLTA    = 2'd1,
    COMPARA  = 2'd2,
    BLOQUEIO = 2'd3
  } estado_t;

  localparam int DEF_N_DIGITS    = 4;
  localparam int DEF_MAX_TRIES   = 3;
  localparam int DEF_LOCK_CYCLES = 50;

endpackage

// File: rtl/borda_subida.sv
// Rising-edge detector with a registered history bit. The history resets to 1
// so a level already high when reset releases never looks like a fresh press.
module borda_subida (
  input  logic clk,
  input  logic reset,
  input  logic sinal,
  output logic borda
);

  logic sinal_ant;

  always_ff @(posedge clk) begin
    if (reset) sinal_ant <= 1'b1;
    else       sinal_ant <= sinal;
  end

  assign borda = sinal & ~sinal_ant;

endmodule

// File: rtl/code_entry_controller.sv
// Keypad code-entry controller: buffers BCD digits, checks them against the
// stored code on confirm, counts consecutive failures and enforces a lockout.
module code_entry_controller
  import digilock_pkg::*;
#(
  parameter int N_DIGITS    = DEF_N_DIGITS,
  parameter int MAX_TRIES   = DEF_MAX_TRIES,
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tecla_acionada,
  input  logic [3:0]            BCD,
  input  logic                  confirma,
  input  logic                  limpa,
  input  logic [4*N_DIGITS-1:0] senha,
  output logic [2:0]            digitos,
  output logic [1:0]            tentativas,
  output logic                  aberto,
  output logic                  erro,
  output logic                  bloqueado
);

  localparam int CODE_W  = 4 * N_DIGITS;
  localparam int TIMER_W = $clog2(LOCK_CYCLES + 1);

  estado_t            estado;
  logic [CODE_W-1:0]  buffer;
  logic [TIMER_W-1:0] lock_timer;
  logic               borda_tecla;
  logic               borda_conf;
  logic [1:0]         tent_inc;
  logic               buffer_cheio;

  borda_subida u_borda_tecla (
    .clk   (clk),
    .reset (reset),
    .sinal (tecla_acionada),
    .borda (borda_tecla)
  );

  borda_subida u_borda_conf (
    .clk   (clk),
    .reset (reset),
    .sinal (confirma),
    .borda (borda_conf)
  );

  assign tent_inc     = tentativas + 2'd1;
  assign buffer_cheio = (digitos == 3'(N_DIGITS));

  // Priority inside ESPERA: limpa, then confirm edge, then digit-key edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado     <= ESPERA;
      buffer     <= '0;
      digitos    <= '0;
      tentativas <= '0;
      aberto     <= 1'b0;
      erro       <= 1'b0;
      bloqueado  <= 1'b0;
      lock_timer <= '0;
    end else begin
      aberto <= 1'b0;
      erro   <= 1'b0;
      unique case (estado)
        ESPERA: begin
          if (limpa) begin
            buffer  <= '0;
            digitos <= '0;
          end else if (borda_conf) begin
            if (buffer_cheio) begin
              estado <= COMPARA;
            end else begin
              erro    <= 1'b1;
              buffer  <= '0;
              digitos <= '0;
            end
          end else if (borda_tecla) begin
            if (BCD <= 4'd9 && !buffer_cheio) begin
              buffer  <= CODE_W'({buffer, BCD});
              digitos <= digitos + 3'd1;
            end
            estado <= SOLTA;
          end
        end
        SOLTA: begin
          if (limpa) begin
            buffer  <= '0;
            digitos <= '0;
          end
          if (!tecla_acionada) estado <= ESPERA;
        end
        COMPARA: begin
          buffer  <= '0;
          digitos <= '0;
          if (buffer == senha) begin
            aberto     <= 1'b1;
            tentativas <= '0;
            estado     <= ESPERA;
          end else begin
            erro       <= 1'b1;
            tentativas <= tent_inc;
            if (tent_inc == 2'(MAX_TRIES)) begin
              estado     <= BLOQUEIO;
              bloqueado  <= 1'b1;
              lock_timer <= TIMER_W'(LOCK_CYCLES - 1);
            end else begin
              estado <= ESPERA;
            end
          end
        end
        BLOQUEIO: begin
          // Timer counts the remaining lockout cycles after the current one.
          if (lock_timer == '0) begin
            bloqueado  <= 1'b0;
            tentativas <= '0;
            buffer     <= '0;
            digitos    <= '0;
            estado     <= ESPERA;
          end else begin
            lock_timer <= lock_timer - 1'b1;
          end
        end
        default: estado <= ESPERA;
      endcase
    end
  end

endmodule

// File: doc/code_entry_controller.md
CODE_ENTRY_CONTROLLER -- requirements
Module: code_entry_controller

Interface
REQ-001 SHALL have parameter N_DIGITS, default 4, number of BCD digits in a code (1..4).
REQ-002 SHALL have parameter MAX_TRIES, default 3, consecutive wrong codes before lockout (1..3).
REQ-003 SHALL have parameter LOCK_CYCLES, default 50, lockout duration in clk cycles (>=1).
REQ-004 SHALL have port clk  input  1  single system clock, all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port tecla_acionada  input  1  key-down level from decimal-to-BCD encoder.
REQ-007 SHALL have port BCD  input  4  digit from encoder, valid while tecla_acionada=1.
REQ-008 SHALL have port confirma  input  1  confirm key level.
REQ-009 SHALL have port limpa  input  1  clear key level.
REQ-010 SHALL have port senha  input  4*N_DIGITS  stored code, first-entered digit in most significant nibble.
REQ-011 SHALL have port digitos  output  3  digits currently buffered.
REQ-012 SHALL have port tentativas  output  2  consecutive failed attempts.
REQ-013 SHALL have port aberto  output  1  one-cycle pulse, code correct.
REQ-014 SHALL have port erro  output  1  one-cycle pulse, code wrong or incomplete.
REQ-015 SHALL have port bloqueado  output  1  level, lockout active.

Function
REQ-016 SHALL implement FSM states ESPERA (accepting), SOLTA (waiting key release), COMPARA (one-cycle check), BLOQUEIO (lockout).
REQ-017 Key accept: in ESPERA, tecla_acionada rising edge (registered prev=0, now=1) with BCD<=9 and digitos<N_DIGITS SHALL shift BCD into buffer low nibble, increment digitos, go to SOLTA.
REQ-018 Key rising edge with BCD>9 or digitos==N_DIGITS SHALL not alter buffer/digitos but SHALL still go to SOLTA.
REQ-019 SOLTA SHALL return to ESPERA on the first cycle tecla_acionada=0; no digit accepted while held.
REQ-020 confirma rising edge in ESPERA with digitos==N_DIGITS SHALL go to COMPARA; aberto/erro asserted the cycle after COMPARA (2 cycles after edge sampled).
REQ-021 confirma rising edge with digitos<N_DIGITS SHALL pulse erro next cycle, clear buffer, not change tentativas.
REQ-022 COMPARA match: aberto=1 one cycle, tentativas<=0, buffer cleared, -> ESPERA.
REQ-023 COMPARA mismatch: erro=1 one cycle, buffer cleared; if tentativas+1==MAX_TRIES -> BLOQUEIO with timer loaded, else tentativas+1, -> ESPERA.
REQ-024 BLOQUEIO SHALL hold bloqueado=1 for exactly LOCK_CYCLES cycles, ignore all key inputs, then -> ESPERA with tentativas=0, buffer empty.
REQ-025 limpa=1 in ESPERA or SOLTA SHALL clear buffer and digitos within one cycle, no erro, tentativas unchanged.
REQ-026 Simultaneous events SHALL resolve limpa > confirma > digit key; lower-priority event is discarded.
REQ-027 Keys held when lockout ends SHALL not be accepted until released and pressed again.

Reset
REQ-028 reset SHALL force ESPERA, buffer=0, digitos=0, tentativas=0, aberto=erro=bloqueado=0, lock timer=0.
REQ-029 Edge-detect history registers SHALL reset to 1 so a key held through reset is not accepted.
REQ-030 reset mid-BLOQUEIO or mid-COMPARA SHALL abort immediately with no aberto/erro pulse.

Structure
REQ-031 Shared package digilock_pkg SHALL hold FSM state encoding and default N_DIGITS/MAX_TRIES/LOCK_CYCLES.
REQ-032 Rising-edge detection SHALL use sub-module borda_subida, instantiated for tecla_acionada and confirma.

Verification
REQ-033 senha=16'h1234; keys 1,2,3,4, confirma -> digitos 1..4, aberto one cycle 2 clk after confirma edge, tentativas=0.
REQ-034 Keys 1,2,3,5, confirma, 3 times (MAX_TRIES=3) -> erro x3, tentativas 1,2, then bloqueado=1 for exactly 50 cycles; keys during lockout ignored.
REQ-035 Key 7 held 10 cycles -> digitos=1 only; press 5th digit after 4 -> digitos stays 4.
REQ-036 Keys 1,2, confirma -> erro pulse, digitos=0, tentativas unchanged; keys 1,2 then limpa with key 3 same cycle -> digitos=0.
REQ-037 reset asserted during BLOQUEIO with key held -> bloqueado=0 next cycle, no digit accepted until key released and re-pressed.
